mult_accumulator: RTL and testbench

//  Downstream consumer of the 4x4 combinational multiplier. Accepts a stream of 8-bit products

---
 rtl/mult_accumulator_pkg.sv | 14 +
 rtl/mult_accumulator_adder.sv | 27 ++
 rtl/mult_accumulator.sv | 112 +++++++++++
 tb/tb_mult_accumulator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_accumulator_pkg.sv
// Shared state encoding and default widths for the product accumulator.
package mult_accumulator_pkg;

  localparam int PROD_W_DEF  = 8;
  localparam int ACC_W_DEF   = 16;
  localparam int COUNT_W_DEF = 4;

  typedef enum logic [1:0] {
    MAC_IDLE  = 2'd0,
    MAC_ACCUM = 2'd1,
    MAC_DONE  = 2'd2
  } mac_state_e;

endpackage

// File: rtl/mult_accumulator_adder.sv
// Accumulator adder: running sum plus zero-extended product, with carry out.
// MAC_SATURATE_EN selects clamping to all-ones on carry instead of wrapping.
module mult_accumulator_adder
  import mult_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [ACC_W-1:0] sum_in,
  input  logic [ACC_W-1:0] prod_in,
  output logic [ACC_W-1:0] sum_out,
  output logic             carry_out
);

  logic [ACC_W:0] total;

  always_comb begin
    total     = {1'b0, sum_in} + {1'b0, prod_in};
    carry_out = total[ACC_W];
`ifdef MAC_SATURATE_EN
    // Once clamped, further carries keep the sum pinned at all-ones.
    sum_out   = carry_out ? '1 : total[ACC_W-1:0];
`else
    sum_out   = total[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/mult_accumulator.sv
// Accumulates a programmed number of products over valid/ready and presents the sum.
// Optional build macro MAC_SATURATE_EN (in the adder) clamps the sum on overflow.
module mult_accumulator
  import mult_accumulator_pkg::*;
#(
  parameter int PROD_W  = PROD_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic               iStart,
  input  logic [COUNT_W-1:0] iLength,
  input  logic               iAbort,
  input  logic               iValid,
  output logic               oReady,
  input  logic [PROD_W-1:0]  iProduct,
  output logic               oValid,
  input  logic               iReady,
  output logic [ACC_W-1:0]   oSum,
  output logic [COUNT_W-1:0] oCount,
  output logic               oOverflow
);

  mac_state_e         state_q, state_d;
  logic [COUNT_W-1:0] len_q, len_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum_next;
  logic               carry;
  logic [COUNT_W-1:0] count_inc;
  logic               beat;

  assign prod_ext  = ACC_W'(iProduct);
  assign count_inc = count_q + COUNT_W'(1);
  assign beat      = ready_q & iValid;

  mult_accumulator_adder #(.ACC_W(ACC_W)) u_adder (
    .sum_in   (sum_q),
    .prod_in  (prod_ext),
    .sum_out  (sum_next),
    .carry_out(carry)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    case (state_q)
      MAC_IDLE: begin
        if (iStart) begin
          len_d   = iLength;
          count_d = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          state_d = (iLength != '0) ? MAC_ACCUM : MAC_DONE;
        end
      end
      MAC_ACCUM: begin
        // Abort wins over a simultaneous beat: the product is discarded.
        if (iAbort) begin
          state_d = MAC_IDLE;
        end else if (beat) begin
          sum_d   = sum_next;
          ovf_d   = ovf_q | carry;
          count_d = count_inc;
          if (count_inc == len_q) state_d = MAC_DONE;
        end
      end
      MAC_DONE: begin
        if (iAbort || iReady) state_d = MAC_IDLE;
      end
      default: state_d = MAC_IDLE;
    endcase
    ready_d = (state_d == MAC_ACCUM);
    valid_d = (state_d == MAC_DONE);
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= MAC_IDLE;
      len_q   <= '0;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign oReady    = ready_q;
  assign oValid    = valid_q;
  assign oSum      = sum_q;
  assign oCount    = count_q;
  assign oOverflow = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Self-checking bench for mult_accumulator: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a sum model.
module tb_mult_accumulator;

  localparam int PROD_W  = 8;
  localparam int ACC_W   = 8;
  localparam int COUNT_W = 4;
  localparam int SUM_MAX = (1 << ACC_W) - 1;

  logic               clock;
  logic               reset_n;
  logic               i_start;
  logic [COUNT_W-1:0] i_length;
  logic               i_abort;
  logic               i_valid;
  logic               o_ready;
  logic [PROD_W-1:0]  i_product;
  logic               o_valid;
  logic               i_ready;
  logic [ACC_W-1:0]   o_sum;
  logic [COUNT_W-1:0] o_count;
  logic               o_overflow;

  int check_count = 0;
  int pass_count  = 0;

  // Transaction-level model: run flags plus an unbounded integer sum.
  bit m_busy, m_done;
  int m_len, m_count, m_sum;

  mult_accumulator #(.PROD_W(PROD_W), .ACC_W(ACC_W), .COUNT_W(COUNT_W)) dut (
    .Clock    (clock),
    .Reset_n  (reset_n),
    .iStart   (i_start),
    .iLength  (i_length),
    .iAbort   (i_abort),
    .iValid   (i_valid),
    .oReady   (o_ready),
    .iProduct (i_product),
    .oValid   (o_valid),
    .iReady   (i_ready),
    .oSum     (o_sum),
    .oCount   (o_count),
    .oOverflow(o_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    check_count++;
    if (actual == expected) pass_count++;
    else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
  endtask

  function automatic int model_sum();
`ifdef MAC_SATURATE_EN
    return (m_sum > SUM_MAX) ? SUM_MAX : m_sum;
`else
    return m_sum % (SUM_MAX + 1);
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_len = 0; m_count = 0; m_sum = 0;
  endtask

  task automatic model_update();
    if (!reset_n) begin
      model_reset();
    end else if (m_busy) begin
      if (i_abort) m_busy = 0;
      else if (i_valid) begin
        m_sum += int'(i_product);
        m_count++;
        if (m_count == m_len) begin m_busy = 0; m_done = 1; end
      end
    end else if (m_done) begin
      if (i_abort || i_ready) m_done = 0;
    end else if (i_start) begin
      m_len = int'(i_length); m_count = 0; m_sum = 0;
      if (m_len == 0) m_done = 1; else m_busy = 1;
    end
  endtask

  task automatic compare_model();
    check_output("model_ready", int'(o_ready), int'(m_busy));
    check_output("model_valid", int'(o_valid), int'(m_done));
    check_output("model_count", int'(o_count), m_count);
    check_output("model_sum", int'(o_sum), model_sum());
    check_output("model_overflow", int'(o_overflow), int'(m_sum > SUM_MAX));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_model();
  endtask

  task automatic apply_stimulus(input bit start, input int len, input bit valid,
                                input int prod, input bit ready, input bit abort);
    i_start   = start;
    i_length  = COUNT_W'(len);
    i_valid   = valid;
    i_product = PROD_W'(prod);
    i_ready   = ready;
    i_abort   = abort;
  endtask

  task automatic check_zero_outputs(input string tag);
    check_output({tag, "_ready"}, int'(o_ready), 0);
    check_output({tag, "_valid"}, int'(o_valid), 0);
    check_output({tag, "_sum"}, int'(o_sum), 0);
    check_output({tag, "_count"}, int'(o_count), 0);
    check_output({tag, "_overflow"}, int'(o_overflow), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    apply_stimulus(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clock);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    cycle();

    // Basic run: 15 + 225 + 6 = 246, result the cycle after the third beat.
    apply_stimulus(1, 3, 0, 0, 0, 0); cycle();
    check_output("basic_ready_after_start", int'(o_ready), 1);
    apply_stimulus(0, 0, 1, 15, 0, 0);  cycle();
    apply_stimulus(0, 0, 1, 225, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 6, 0, 0);   cycle();
    check_output("basic_valid", int'(o_valid), 1);
    check_output("basic_sum", int'(o_sum), 246);
    check_output("basic_count", int'(o_count), 3);
    check_output("basic_overflow", int'(o_overflow), 0);
    check_output("basic_ready_done", int'(o_ready), 0);
    apply_stimulus(0, 0, 0, 0, 1, 0); cycle();
    check_output("basic_idle_valid", int'(o_valid), 0);
    check_output("basic_idle_sum_held", int'(o_sum), 246);

    // Backpressure: gapped beats 7 and 9, consumer stalls five cycles.
    apply_stimulus(1, 2, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 7, 0, 0); cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 9, 0, 0); cycle();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_output("bp_valid_held", int'(o_valid), 1);
      check_output("bp_sum_stable", int'(o_sum), 16);
    end
    apply_stimulus(0, 0, 0, 0, 1, 0); cycle();
    check_output("bp_released", int'(o_valid), 0);

    // Zero length goes straight to DONE; beats and iStart there are ignored.
    apply_stimulus(1, 0, 0, 0, 0, 0); cycle();
    check_output("zero_valid", int'(o_valid), 1);
    check_output("zero_sum", int'(o_sum), 0);
    check_output("zero_ready", int'(o_ready), 0);
    apply_stimulus(0, 0, 1, 99, 0, 0); cycle();
    check_output("zero_no_beat", int'(o_count), 0);
    apply_stimulus(1, 5, 0, 0, 0, 0); cycle();
    check_output("start_in_done_sum", int'(o_sum), 0);
    check_output("start_in_done_valid", int'(o_valid), 1);
    apply_stimulus(0, 0, 0, 0, 1, 0); cycle();

    // Overflow: 200 + 100 exceeds 8 bits.
    apply_stimulus(1, 2, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 200, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 100, 0, 0); cycle();
`ifdef MAC_SATURATE_EN
    check_output("ovf_sum", int'(o_sum), 255);
`else
    check_output("ovf_sum", int'(o_sum), 44);
`endif
    check_output("ovf_flag", int'(o_overflow), 1);
    apply_stimulus(0, 0, 0, 0, 1, 0); cycle();

    // Abort colliding with a beat drops the product.
    apply_stimulus(1, 4, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 10, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 20, 0, 1); cycle();
    check_output("abort_sum", int'(o_sum), 10);
    check_output("abort_count", int'(o_count), 1);
    check_output("abort_ready", int'(o_ready), 0);
    apply_stimulus(0, 0, 0, 0, 1, 0);
    repeat (2) begin
      cycle();
      check_output("abort_no_valid", int'(o_valid), 0);
    end

    // Asynchronous reset in the middle of a run.
    apply_stimulus(1, 5, 0, 0, 0, 0); cycle();
    apply_stimulus(0, 0, 1, 50, 0, 0); cycle();
    #2 reset_n = 1'b0;
    #1 check_zero_outputs("midrun_reset");
    model_reset();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    cycle();
    reset_n = 1'b1;
    cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      apply_stimulus(($urandom % 3) == 0, $urandom_range(0, 15), ($urandom % 10) < 7,
                     $urandom_range(0, 255), ($urandom % 3) == 0, ($urandom % 40) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
